// File: rtl/axi_sram_slave.sv
// Single-port AXI3 slave RAM. Single-beat reads are queued and answered in
// order after a fixed latency; a write commits once its AW and W beats are
// both held.
module axi_sram_slave #(
  parameter int ADDR_WIDTH = 16,
  parameter int RD_LAT     = 2,
  parameter int RQ_DEPTH   = 2
) (
  input  logic        aclk,
  input  logic        reset,
  // AR
  input  logic [3:0]  arid,
  input  logic [31:0] araddr,
  input  logic [7:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  input  logic [1:0]  arlock,
  input  logic [3:0]  arcache,
  input  logic [2:0]  arprot,
  input  logic        arvalid,
  output logic        arready,
  // R
  output logic [3:0]  rid,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic        rvalid,
  input  logic        rready,
  // AW
  input  logic [3:0]  awid,
  input  logic [31:0] awaddr,
  input  logic [7:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic [1:0]  awburst,
  input  logic [1:0]  awlock,
  input  logic [3:0]  awcache,
  input  logic [2:0]  awprot,
  input  logic        awvalid,
  output logic        awready,
  // W
  input  logic [3:0]  wid,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  input  logic        wvalid,
  output logic        wready,
  // B
  output logic [3:0]  bid,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);

  localparam int QW = (RQ_DEPTH > 1) ? $clog2(RQ_DEPTH) : 1;
  localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  typedef struct packed {
    logic [3:0]            id;
    logic [ADDR_WIDTH-1:0] idx;
  } rd_req_t;

  logic [31:0] mem [2**ADDR_WIDTH];

  // read queue
  rd_req_t       rq [RQ_DEPTH];
  logic [QW-1:0] rq_rd, rq_wr;
  logic [QW:0]   rq_cnt;
  logic          rq_empty, rq_full, ar_push, r_pop;
  rd_req_t       ar_req, head;

  // read countdown
  logic          rd_run, rd_start, rd_fire;
  logic [CW-1:0] rd_cnt, eff_cnt;

  // write capture
  logic                  aw_held, w_held, commit;
  logic [3:0]            aw_id;
  logic [ADDR_WIDTH-1:0] aw_idx;
  logic [31:0]           w_data;
  logic [3:0]            w_strb;

  // Sideband fields are accepted but have no effect on a single-beat RAM.
  logic unused_ok;
  assign unused_ok = ^{arlen, arsize, arburst, arlock, arcache, arprot,
                       awlen, awsize, awburst, awlock, awcache, awprot,
                       wid, wlast, araddr, awaddr};

  assign rq_empty = (rq_cnt == '0);
  assign rq_full  = (rq_cnt == (QW+1)'(RQ_DEPTH));
  assign arready  = !rq_full;
  assign awready  = !aw_held;
  assign wready   = !w_held;
  assign ar_push  = arvalid && arready;
  assign r_pop    = rvalid && rready;
  assign commit   = aw_held && w_held && !bvalid;
  assign ar_req   = '{id: arid, idx: araddr[ADDR_WIDTH+1:2]};

  // With an empty queue the incoming AR is the head in its handshake cycle,
  // so the countdown starts there and an idle read answers in RD_LAT cycles.
  // After a pop the next head starts one cycle later, which leaves a gap
  // between R beats.
  always_comb begin
    head     = rq_empty ? ar_req : rq[rq_rd];
    rd_start = !rvalid && !rd_run && (!rq_empty || ar_push);
    eff_cnt  = rd_start ? CW'(RD_LAT-1) : rd_cnt;
    rd_fire  = (rd_start || rd_run) && (eff_cnt == '0);
  end

  // Read-queue storage; entries need no reset.
  always_ff @(posedge aclk) begin
    if (ar_push) rq[rq_wr] <= ar_req;
  end

  // Read-queue pointers and occupancy. The head leaves only on its R handshake.
  always_ff @(posedge aclk) begin
    if (reset) begin
      rq_rd  <= '0;
      rq_wr  <= '0;
      rq_cnt <= '0;
    end else begin
      if (ar_push) rq_wr <= rq_wr + 1'b1;
      if (r_pop)   rq_rd <= rq_rd + 1'b1;
      case ({ar_push, r_pop})
        2'b10:   rq_cnt <= rq_cnt + 1'b1;
        2'b01:   rq_cnt <= rq_cnt - 1'b1;
        default: rq_cnt <= rq_cnt;
      endcase
    end
  end

  // Latency countdown and the registered R channel.
  always_ff @(posedge aclk) begin
    if (reset) begin
      rd_run <= 1'b0;
      rd_cnt <= '0;
      rvalid <= 1'b0;
      rid    <= '0;
      rdata  <= '0;
      rresp  <= '0;
      rlast  <= 1'b0;
    end else begin
      if (r_pop) rvalid <= 1'b0;
      if (rd_fire) begin
        rd_run <= 1'b0;
        rvalid <= 1'b1;
        rid    <= head.id;
        rdata  <= mem[head.idx];
        rresp  <= 2'b00;
        rlast  <= 1'b1;
      end else if (rd_start || rd_run) begin
        rd_run <= 1'b1;
        rd_cnt <= eff_cnt - 1'b1;
      end
    end
  end

  // AW/W capture, commit and the B channel.
  always_ff @(posedge aclk) begin
    if (reset) begin
      aw_held <= 1'b0;
      w_held  <= 1'b0;
      aw_id   <= '0;
      aw_idx  <= '0;
      w_data  <= '0;
      w_strb  <= '0;
      bvalid  <= 1'b0;
      bid     <= '0;
      bresp   <= '0;
    end else begin
      if (bvalid && bready) bvalid <= 1'b0;
      if (commit) begin
        aw_held <= 1'b0;
        w_held  <= 1'b0;
        bvalid  <= 1'b1;
        bid     <= aw_id;
        bresp   <= 2'b00;
      end
      if (awvalid && awready) begin
        aw_held <= 1'b1;
        aw_id   <= awid;
        aw_idx  <= awaddr[ADDR_WIDTH+1:2];
      end
      if (wvalid && wready) begin
        w_held <= 1'b1;
        w_data <= wdata;
        w_strb <= wstrb;
      end
    end
  end

  // Byte-lane memory write; contents survive reset.
  always_ff @(posedge aclk) begin
    if (!reset && commit) begin
      for (int k = 0; k < 4; k++)
        if (w_strb[k]) mem[aw_idx][8*k +: 8] <= w_data[8*k +: 8];
    end
  end

endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed plus randomized bench for axi_sram_slave against a word-array
// reference model.
module tb_axi_sram_slave;
  localparam int AW = 16;

  logic        aclk = 1'b0, reset;
  logic [3:0]  arid;  logic [31:0] araddr;
  logic [7:0]  arlen; logic [2:0] arsize; logic [1:0] arburst, arlock;
  logic [3:0]  arcache; logic [2:0] arprot;
  logic        arvalid, arready;
  logic [3:0]  rid;   logic [31:0] rdata; logic [1:0] rresp;
  logic        rlast, rvalid, rready;
  logic [3:0]  awid;  logic [31:0] awaddr;
  logic [7:0]  awlen; logic [2:0] awsize; logic [1:0] awburst, awlock;
  logic [3:0]  awcache; logic [2:0] awprot;
  logic        awvalid, awready;
  logic [3:0]  wid;   logic [31:0] wdata; logic [3:0] wstrb;
  logic        wlast, wvalid, wready;
  logic [3:0]  bid;   logic [1:0] bresp;
  logic        bvalid, bready;

  axi_sram_slave #(.ADDR_WIDTH(AW), .RD_LAT(2), .RQ_DEPTH(2)) dut (
    .aclk(aclk), .reset(reset),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arlock(arlock), .arcache(arcache), .arprot(arprot),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
    .awburst(awburst), .awlock(awlock), .awcache(awcache), .awprot(awprot),
    .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 aclk = ~aclk;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] ref_mem [int];

  task automatic tick();
    @(posedge aclk); #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Word index: byte address / 4, wrapped to the memory size.
  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) % (32'd1 << AW));
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    if (ref_mem.exists(widx(a))) return ref_mem[widx(a)];
    return 32'hxxxx_xxxx;
  endfunction

  task automatic ref_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] w;
    w = ref_mem.exists(widx(a)) ? ref_mem[widx(a)] : 32'h0;
    for (int k = 0; k < 4; k++) if (s[k]) w[8*k +: 8] = d[8*k +: 8];
    ref_mem[widx(a)] = w;
  endtask

  task automatic do_write(input logic [3:0] id, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, input int aw_dly, input int w_dly);
    bit aw_done, w_done, hs_aw, hs_w;
    int n;
    aw_done = 0; w_done = 0; n = 0;
    awid = id; awaddr = a; wdata = d; wstrb = s; bready = 1'b1;
    while (!(aw_done && w_done) && n < 50) begin
      awvalid = !aw_done && (n >= aw_dly);
      wvalid  = !w_done && (n >= w_dly);
      hs_aw = awvalid && awready;
      hs_w  = wvalid && wready;
      tick(); n++;
      if (hs_aw) aw_done = 1;
      if (hs_w)  w_done = 1;
    end
    awvalid = 1'b0; wvalid = 1'b0;
    chk("wr_handshake", 32'(aw_done && w_done), 32'd1);
    n = 0;
    while (!bvalid && n < 20) begin tick(); n++; end
    chk("wr_bvalid", 32'(bvalid), 32'd1);
    chk("wr_bid", 32'(bid), 32'(id));
    chk("wr_bresp", 32'(bresp), 32'd0);
    tick();
    ref_wr(a, d, s);
  endtask

  task automatic do_read(input logic [3:0] id, input logic [31:0] a, output logic [31:0] d);
    bit hs;
    int n;
    hs = 0; n = 0;
    arid = id; araddr = a; rready = 1'b1;
    while (!hs && n < 50) begin
      arvalid = 1'b1;
      hs = arready;
      tick(); n++;
    end
    arvalid = 1'b0;
    n = 0;
    while (!rvalid && n < 20) begin tick(); n++; end
    chk("rd_rvalid", 32'(rvalid), 32'd1);
    chk("rd_rid", 32'(rid), 32'(id));
    chk("rd_rlast", 32'(rlast), 32'd1);
    chk("rd_rresp", 32'(rresp), 32'd0);
    d = rdata;
    tick();
  endtask

  initial begin
    logic [31:0] d, d0;
    logic [3:0]  got_id [$];
    logic [31:0] got_d  [$];
    bit bseen;

    reset = 1'b1;
    arid = '0; araddr = '0; arlen = 8'h3; arsize = 3'h2; arburst = 2'h1;
    arlock = '0; arcache = '0; arprot = '0; arvalid = 1'b0; rready = 1'b1;
    awid = '0; awaddr = '0; awlen = 8'h3; awsize = 3'h2; awburst = 2'h1;
    awlock = '0; awcache = '0; awprot = '0; awvalid = 1'b0;
    wid = 4'hA; wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b1;

    // reset
    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk("rst_arready", 32'(arready), 32'd1);
    chk("rst_awready", 32'(awready), 32'd1);
    chk("rst_wready", 32'(wready), 32'd1);
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_bvalid", 32'(bvalid), 32'd0);
    chk("rst_rid", 32'(rid), 32'd0);
    chk("rst_bid", 32'(bid), 32'd0);
    chk("rst_rdata", rdata, 32'd0);

    // write then read, exact timing
    awid = 4'd3; awaddr = 32'h100; wdata = 32'hDEADBEEF; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1;
    tick();                               // t+1
    awvalid = 1'b0; wvalid = 1'b0;
    chk("wt_bvalid_t1", 32'(bvalid), 32'd0);
    chk("wt_awready_t1", 32'(awready), 32'd0);
    tick();                               // t+2
    chk("wt_bvalid_t2", 32'(bvalid), 32'd1);
    chk("wt_bid", 32'(bid), 32'd3);
    chk("wt_bresp", 32'(bresp), 32'd0);
    tick();                               // t+3
    chk("wt_bvalid_t3", 32'(bvalid), 32'd0);
    ref_wr(32'h100, 32'hDEADBEEF, 4'hF);
    arid = 4'd5; araddr = 32'h100; arvalid = 1'b1;
    tick();
    arvalid = 1'b0;
    chk("rt_rvalid_t1", 32'(rvalid), 32'd0);
    tick();
    chk("rt_rvalid_t2", 32'(rvalid), 32'd1);
    chk("rt_rdata", rdata, 32'hDEADBEEF);
    chk("rt_rid", 32'(rid), 32'd5);
    chk("rt_rlast", 32'(rlast), 32'd1);
    tick();
    chk("rt_rvalid_t3", 32'(rvalid), 32'd0);

    // partial strobe
    do_write(4'd1, 32'h100, 32'h11223344, 4'b0101, 0, 0);
    do_read(4'd2, 32'h100, d);
    chk("strb_rdata", d, 32'hDE22BE44);

    // W before AW; a read registered before the commit sees the old word
    do_write(4'd0, 32'h200, 32'hAAAA5555, 4'hF, 0, 0);
    wdata = 32'h12345678; wstrb = 4'hF; wvalid = 1'b1;     // cycle 0
    tick(); wvalid = 1'b0;                                 // cycle 1
    chk("wfirst_wready_c1", 32'(wready), 32'd0);
    tick();                                                // cycle 2
    chk("wfirst_wready_c2", 32'(wready), 32'd0);
    arid = 4'd7; araddr = 32'h200; arvalid = 1'b1;
    tick(); arvalid = 1'b0;                                // cycle 3
    chk("wfirst_wready_c3", 32'(wready), 32'd0);
    awid = 4'd9; awaddr = 32'h200; awvalid = 1'b1;
    tick(); awvalid = 1'b0;                                // cycle 4
    chk("wfirst_bvalid_c4", 32'(bvalid), 32'd0);
    chk("wfirst_rvalid_c4", 32'(rvalid), 32'd1);
    chk("wfirst_rid", 32'(rid), 32'd7);
    chk("wfirst_old_data", rdata, ref_rd(32'h200));
    tick();                                                // cycle 5
    chk("wfirst_bvalid_c5", 32'(bvalid), 32'd1);
    chk("wfirst_bid", 32'(bid), 32'd9);
    tick();
    ref_wr(32'h200, 32'h12345678, 4'hF);
    do_read(4'd8, 32'h200, d);
    chk("wfirst_new_data", d, ref_rd(32'h200));

    // read backpressure with a full queue
    do_write(4'd2, 32'h300, 32'h0BADF00D, 4'hF, 1, 0);
    rready = 1'b0;
    arid = 4'd1; araddr = 32'h100; arvalid = 1'b1;         // c0
    chk("bp_arready_c0", 32'(arready), 32'd1);
    tick(); arid = 4'd2; araddr = 32'h200;                 // c1
    chk("bp_arready_c1", 32'(arready), 32'd1);
    tick(); arid = 4'd6; araddr = 32'h300;                 // c2
    chk("bp_arready_full", 32'(arready), 32'd0);
    chk("bp_rvalid", 32'(rvalid), 32'd1);
    chk("bp_rid1", 32'(rid), 32'd1);
    d0 = rdata;
    tick(); tick();                                        // c4
    chk("bp_arready_held", 32'(arready), 32'd0);
    chk("bp_rdata_stable", rdata, d0);
    chk("bp_rdata1", rdata, ref_rd(32'h100));
    rready = 1'b1;
    tick();                                                // c5
    chk("bp_arready_after_pop", 32'(arready), 32'd1);
    tick(); arvalid = 1'b0;                                // c6
    for (int n = 0; n < 30 && got_id.size() < 2; n++) begin
      if (rvalid) begin got_id.push_back(rid); got_d.push_back(rdata); end
      tick();
    end
    chk("bp_beats", 32'(got_id.size()), 32'd2);
    if (got_id.size() == 2) begin
      chk("bp_rid2", 32'(got_id[0]), 32'd2);
      chk("bp_rdata2", got_d[0], ref_rd(32'h200));
      chk("bp_rid6", 32'(got_id[1]), 32'd6);
      chk("bp_rdata6", got_d[1], ref_rd(32'h300));
    end

    // reset with only AW held
    awid = 4'd4; awaddr = 32'h100; awvalid = 1'b1;
    tick(); awvalid = 1'b0;
    reset = 1'b1; tick(); tick(); reset = 1'b0; tick();
    chk("mid_awready", 32'(awready), 32'd1);
    chk("mid_bvalid", 32'(bvalid), 32'd0);
    wdata = 32'hFFFFFFFF; wstrb = 4'hF; wvalid = 1'b1;
    tick(); wvalid = 1'b0;
    bseen = 0;
    repeat (6) begin if (bvalid) bseen = 1; tick(); end
    chk("mid_no_commit", 32'(bseen), 32'd0);
    reset = 1'b1; tick(); reset = 1'b0; tick();
    chk("mid_wready", 32'(wready), 32'd1);
    do_read(4'd3, 32'h100, d);
    chk("mid_mem_kept", d, ref_rd(32'h100));

    // randomized traffic over a few words, with aliasing address bits
    for (int i = 0; i < 8; i++)
      do_write(4'(i), 32'h1000 + 32'(i*4), $urandom(), 4'hF, 0, 0);
    for (int i = 0; i < 60; i++) begin
      logic [31:0] a;
      a = ($urandom() & 32'hFFFC_0000) | (32'h1000 + 32'($urandom_range(0, 7) * 4))
          | ($urandom() & 32'h3);
      if ($urandom_range(0, 1) == 0)
        do_write(4'($urandom()), a, $urandom(), 4'($urandom_range(0, 15)),
                 $urandom_range(0, 2), $urandom_range(0, 2));
      else begin
        do_read(4'($urandom()), a, d);
        chk("rand_rdata", d, ref_rd(a));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
